// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined input selector.
//   state_e       : controller states (IDLE = direct selects, SCAN = full sweep)
//   sel_w_for     : minimum select width able to address n inputs
//   params_legal  : parameter legality check used at elaboration time
package mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    function automatic int unsigned sel_w_for(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_legal(input int unsigned n, input int unsigned dw,
                                        input int unsigned sw);
        return (n >= 2) && (n <= 256) && (dw >= 1) && (sw >= sel_w_for(n)) && (sw <= 16);
    endfunction

endpackage

// File: rtl/mux_sel_core.sv
// Combinational NUM_INPUTS:1 selector.
//   inp_flat : packed inputs, input i at [i*DATA_W +: DATA_W]
//   idx      : index to select
//   data     : selected input, or 0 when idx is out of range
//   err      : idx >= NUM_INPUTS
module mux_sel_core #(
    parameter int unsigned NUM_INPUTS = 31,
    parameter int unsigned DATA_W     = 2,
    parameter int unsigned SEL_W      = 5
) (
    input  logic [NUM_INPUTS*DATA_W-1:0] inp_flat,
    input  logic [SEL_W-1:0]             idx,
    output logic [DATA_W-1:0]            data,
    output logic                         err
);

    // Defaults cover every index that matches no input, so no latch is possible.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (idx == SEL_W'(i)) begin
                data = inp_flat[i*DATA_W +: DATA_W];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered input selector with valid/ready output and a full-sweep scan mode.
//   clk, rst    : clock, asynchronous active-high reset
//   inp_flat    : packed inputs, input i at [i*DATA_W +: DATA_W]
//   sel_valid/sel/sel_ready : direct select request handshake
//   scan_start  : request a sweep of inputs 0..NUM_INPUTS-1
//   out/out_valid/out_ready : registered result handshake
//   out_idx     : index that produced out
//   sel_err     : result came from an out-of-range select
//   scan_busy   : sweep in progress
//   scan_last   : result is the final sweep element
module mux_sel_pipe
    import mux_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 31,
    parameter int unsigned DATA_W     = 2,
    parameter int unsigned SEL_W      = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_INPUTS*DATA_W-1:0] inp_flat,
    input  logic                         sel_valid,
    input  logic [SEL_W-1:0]             sel,
    output logic                         sel_ready,
    input  logic                         scan_start,
    output logic [DATA_W-1:0]            out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_W-1:0]             out_idx,
    output logic                         sel_err,
    output logic                         scan_busy,
    output logic                         scan_last
);

    if (!params_legal(NUM_INPUTS, DATA_W, SEL_W)) begin : g_param_check
        $error("mux_sel_pipe: illegal NUM_INPUTS/DATA_W/SEL_W combination");
    end

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    out_q, out_d;
    logic                 valid_q, valid_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic                 err_q, err_d;
    logic                 last_q, last_d;

    logic                 adv;
    logic                 last_elem;
    logic [SEL_W-1:0]     core_idx;
    logic [DATA_W-1:0]    core_data;
    logic                 core_err;

    // Output register may take a new value when empty or being drained.
    assign adv       = !valid_q || out_ready;
    assign last_elem = (cnt_q == SEL_W'(NUM_INPUTS - 1));
    // One selector serves both paths; the sweep counter wins while scanning.
    assign core_idx  = (state_q == SCAN) ? cnt_q : sel;

    mux_sel_core #(
        .NUM_INPUTS (NUM_INPUTS),
        .DATA_W     (DATA_W),
        .SEL_W      (SEL_W)
    ) u_core (
        .inp_flat (inp_flat),
        .idx      (core_idx),
        .data     (core_data),
        .err      (core_err)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter only moves when an element is loaded.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (scan_start && adv) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (adv) begin
                    if (last_elem) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Handshake outputs; scan_start in IDLE blocks the concurrent select.
    always_comb begin
        sel_ready = (state_q == IDLE) && adv && !scan_start;
        scan_busy = (state_q == SCAN);
    end

    // Output register next value
    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        err_d   = err_q;
        last_d  = last_q;
        if (adv) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (state_q == SCAN) begin
                out_d   = core_data;
                idx_d   = cnt_q;
                err_d   = 1'b0;
                last_d  = last_elem;
                valid_d = 1'b1;
            end else if (sel_valid && sel_ready) begin
                out_d   = core_data;
                idx_d   = sel;
                err_d   = core_err;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign sel_err   = err_q;
    assign scan_last = last_q;

endmodule
